// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - per-key edge detect, pending latch and cooldown,
// with a round-robin valid/ready event issuer.
module key_event_arbiter #(
  parameter int NUM_KEYS = 4,
  parameter int COOLDOWN = 16,
  localparam int IDW = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [IDW-1:0]      evt_id,
  output logic [NUM_KEYS-1:0] pending,
  output logic [NUM_KEYS-1:0] dropped
);
  localparam int CW = (COOLDOWN == 0) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0]  CD_LOAD = CW'(COOLDOWN);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_KEYS - 1);

  logic [NUM_KEYS-1:0] key_d;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] cd_busy;
  logic [NUM_KEYS-1:0] grant_vec;
  logic [NUM_KEYS-1:0] accept_vec;
  logic [NUM_KEYS-1:0] drop_vec;
  logic [CW-1:0]       cooldown [NUM_KEYS];
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      sel;
  logic [IDW-1:0]      cand;
  logic                found;
  logic                slot_free;
  logic                grant;
  int                  idx;

  assign slot_free = ~evt_valid | evt_ready;
  assign rise      = keys & ~key_d;

  // Search registered pending starting at ptr; edges latched this cycle wait a cycle.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
      cand = IDW'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    grant     = slot_free & enable & found;
    grant_vec = '0;
    cd_busy   = '0;
    if (grant) grant_vec[sel] = 1'b1;
    for (int i = 0; i < NUM_KEYS; i++) cd_busy[i] = (cooldown[i] != '0);
  end

  assign accept_vec = rise & {NUM_KEYS{enable}} & ~cd_busy & ~pending & ~grant_vec;
  assign drop_vec   = rise & {NUM_KEYS{enable}} & (cd_busy | pending | grant_vec);

  // key_d tracks keys even in reset so a key held through reset gives no edge.
  always_ff @(posedge clk) begin
    key_d <= keys;
    if (reset) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      pending   <= '0;
      dropped   <= '0;
      ptr       <= '0;
      for (int i = 0; i < NUM_KEYS; i++) cooldown[i] <= '0;
    end else begin
      dropped <= drop_vec;
      pending <= (pending & ~grant_vec) | accept_vec;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (grant_vec[i])    cooldown[i] <= CD_LOAD;
        else if (cd_busy[i]) cooldown[i] <= cooldown[i] - CW'(1);
      end
      if (grant) begin
        evt_valid <= 1'b1;
        evt_id    <= sel;
        ptr       <= (sel == LAST_ID) ? '0 : sel + IDW'(1);
      end else if (slot_free) begin
        evt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed vector table plus hand sequences for
// key_event_arbiter (NUM_KEYS=4, COOLDOWN=16 and a COOLDOWN=0 companion).
module tb_key_event_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] keys;
  logic       evt_ready;
  logic       evt_valid, evt_valid0;
  logic [1:0] evt_id, evt_id0;
  logic [3:0] pending, pending0;
  logic [3:0] dropped, dropped0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  key_event_arbiter #(.NUM_KEYS(4), .COOLDOWN(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .keys(keys), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .pending(pending), .dropped(dropped)
  );

  key_event_arbiter #(.NUM_KEYS(4), .COOLDOWN(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .keys(keys), .evt_ready(evt_ready),
    .evt_valid(evt_valid0), .evt_id(evt_id0), .pending(pending0), .dropped(dropped0)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] k;
    logic       en;
    logic       rdy;
    logic       v;
    logic [1:0] id;
    logic [3:0] p;
    logic [3:0] d;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] k, input logic en, input logic rdy,
                     input logic v, input logic [1:0] id, input logic [3:0] p, input logic [3:0] d);
    vec_t r;
    r = '{rst: rst, k: k, en: en, rdy: rdy, v: v, id: id, p: p, d: d};
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; keys = 4'b0000; evt_ready = 1'b1;
    tick();
    tick();
    chk("reset_valid", 32'(evt_valid), 0);
    chk("reset_id", 32'(evt_id), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_dropped", 32'(dropped), 0);
    reset = 1'b0;

    // single press
    add(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 1, 1, 0, 0, 4'b0001, 4'b0000);
    add(0, 4'b0001, 1, 1, 1, 0, 4'b0000, 4'b0000);
    add(0, 4'b0001, 1, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
    // simultaneous press from ptr=0
    add(1, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 1, 0, 0, 4'b1111, 4'b0000);
    add(0, 4'b1111, 1, 1, 1, 0, 4'b1110, 4'b0000);
    add(0, 4'b1111, 1, 1, 1, 1, 4'b1100, 4'b0000);
    add(0, 4'b1111, 1, 1, 1, 2, 4'b1000, 4'b0000);
    add(0, 4'b1111, 1, 1, 1, 3, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 1, 0, 3, 4'b0000, 4'b0000);
    // backpressure with key 3 arriving while id 1 is stalled
    add(1, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 1, 1, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0010, 1, 0, 0, 0, 4'b0010, 4'b0000);
    add(0, 4'b0010, 1, 0, 1, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) add(0, 4'b1010, 1, 0, 1, 1, 4'b1000, 4'b0000);
    add(0, 4'b1010, 1, 1, 1, 3, 4'b0000, 4'b0000);
    add(0, 4'b1010, 1, 1, 0, 3, 4'b0000, 4'b0000);
    // duplicate rise while pending, then disabled press and held event
    add(0, 4'b1011, 1, 0, 0, 3, 4'b0001, 4'b0000);
    add(0, 4'b1011, 1, 0, 1, 0, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 0, 4'b0100, 4'b0000);
    add(0, 4'b1011, 1, 0, 1, 0, 4'b0100, 4'b0000);
    add(0, 4'b1111, 1, 0, 1, 0, 4'b0100, 4'b0100);
    add(0, 4'b1111, 1, 0, 1, 0, 4'b0100, 4'b0000);
    add(0, 4'b1101, 0, 0, 1, 0, 4'b0100, 4'b0000);
    add(0, 4'b1111, 0, 0, 1, 0, 4'b0100, 4'b0000);
    add(0, 4'b1111, 0, 1, 0, 0, 4'b0100, 4'b0000);
    add(0, 4'b1111, 1, 1, 1, 2, 4'b0000, 4'b0000);
    add(0, 4'b1111, 1, 1, 0, 2, 4'b0000, 4'b0000);

    foreach (tbl[n]) begin
      reset = tbl[n].rst; keys = tbl[n].k; enable = tbl[n].en; evt_ready = tbl[n].rdy;
      tick();
      chk($sformatf("vec%0d_valid", n), 32'(evt_valid), 32'(tbl[n].v));
      if (tbl[n].v) chk($sformatf("vec%0d_id", n), 32'(evt_id), 32'(tbl[n].id));
      chk($sformatf("vec%0d_pending", n), 32'(pending), 32'(tbl[n].p));
      chk($sformatf("vec%0d_dropped", n), 32'(dropped), 32'(tbl[n].d));
    end
    reset = 1'b0; enable = 1'b1; evt_ready = 1'b1;

    // round robin starting from ptr=2
    keys = 4'b0000;
    do_reset();
    keys = 4'b0010; tick(); tick();
    chk("rr2_seed_id", 32'(evt_id), 1);
    keys = 4'b0000;
    for (int i = 0; i < 20; i++) tick();
    keys = 4'b1111; tick();
    chk("rr2_pending", 32'(pending), 4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr2_valid%0d", i), 32'(evt_valid), 1);
      chk($sformatf("rr2_id%0d", i), 32'(evt_id), 32'((i + 2) % 4));
    end
    tick();
    chk("rr2_idle", 32'(evt_valid), 0);

    // cooldown: re-press 5 cycles after grant drops, 17 cycles after is accepted
    keys = 4'b0000;
    do_reset();
    keys = 4'b0001; tick(); tick();
    chk("cd_grant", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));
    for (int k = 1; k <= 18; k++) begin
      keys = (k == 5 || k >= 17) ? 4'b0001 : 4'b0000;
      tick();
      if (k == 5) begin
        chk("cd_drop_pulse", 32'(dropped), 4'b0001);
        chk("cd_drop_pending", 32'(pending), 0);
      end
      if (k == 6) chk("cd_drop_once", 32'({evt_valid, dropped}), 0);
      if (k == 17) chk("cd_accept", 32'({dropped, pending}), 32'({4'b0000, 4'b0001}));
      if (k == 18) chk("cd_event", 32'({evt_valid, evt_id}), 32'({1'b1, 2'd0}));
    end

    // COOLDOWN=0 companion accepts a re-press 2 cycles after the grant
    keys = 4'b0000;
    do_reset();
    keys = 4'b0001; tick(); tick();
    chk("cd0_grant", 32'({evt_valid0, evt_id0}), 32'({1'b1, 2'd0}));
    keys = 4'b0000; tick();
    keys = 4'b0001; tick();
    chk("cd0_pending", 32'({dropped0, pending0}), 32'({4'b0000, 4'b0001}));
    chk("cd16_dropped", 32'({dropped, pending}), 32'({4'b0001, 4'b0000}));
    tick();
    chk("cd0_event", 32'({evt_valid0, evt_id0}), 32'({1'b1, 2'd0}));
    chk("cd16_no_event", 32'(evt_valid), 0);

    // keys held through reset produce nothing
    keys = 4'b0101; reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("held_%0d", i), 32'({evt_valid, pending, dropped}), 0);
    end

    // reset while an event is presented and more are pending
    keys = 4'b0000;
    do_reset();
    evt_ready = 1'b0;
    keys = 4'b0001; tick(); tick();
    keys = 4'b0111; tick();
    chk("midrst_pre", 32'({evt_valid, pending}), 32'({1'b1, 4'b0110}));
    reset = 1'b1; tick();
    chk("midrst_post", 32'({evt_valid, pending, dropped}), 0);
    reset = 1'b0;
    tick();
    chk("midrst_after", 32'({evt_valid, pending, dropped}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
